conv1_layer_ctrl: RTL and testbench
===================================

Name: conv1_layer_ctrl

Overview:
- Sequencer for the first convolution layer (5x5 conv, ReLU, 2x2 maxpool, CO channels).
- Takes an input-map pixel stream from the AXI4-Lite register side with a valid/ready handshake and replays it into the layer's input-BRAM write path.
- Then drives the layer's clock enable through the convolution of all channels, and packs pooled results into a flat result-buffer write port with channel tracking.
- Reports busy, done and protocol errors to the register file.

Parameters:
- I_SIZE, 28, input map side
- K_SIZE, 5, kernel side
- P_SIZE, 2, pool side
- CO, 4, output channels
- I_BW, 8, pixel width
- O_BW, 16, pooled result width
- PIX_AW, 10, pixel counter width; must satisfy 2^PIX_AW >= I_SIZE*I_SIZE
- RES_AW, 10, result address width; must satisfy 2^RES_AW >= CO*OUT_PER_CH
- Derived constants: N_PIX=I_SIZE*I_SIZE=784; OUT_SIDE=(I_SIZE-K_SIZE+1)/P_SIZE=12; OUT_PER_CH=OUT_SIDE*OUT_SIDE=144.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start pulse from the register file
- i_abort  in  1  one-cycle abort pulse
- i_pix_valid  in  1  pixel available
- i_pix_data  in  I_BW  signed pixel
- o_pix_ready  out  1  pixel accepted when valid&&ready
- o_layer_ce  out  1  layer clock enable
- o_layer_mem_we  out  1  layer input-BRAM write phase select
- o_layer_fmap  out  I_BW  pixel to layer
- o_layer_user_reset  out  1  layer soft reset
- i_layer_en  in  1  pooled result valid
- i_layer_result  in  O_BW  pooled result
- i_layer_ch_end  in  1  channel finished pulse
- i_layer_allch_end  in  1  all channels finished (level)
- o_res_we  out  1  result buffer write strobe
- o_res_addr  out  RES_AW  result buffer address
- o_res_data  out  O_BW  result data
- o_ch_idx  out  2  channel currently being computed
- o_busy  out  1  FSM not in IDLE or DONE
- o_done  out  1  sticky completion flag
- o_err  out  1  sticky error flag

Behaviour:
- Reset (rst high, asynchronous): state=IDLE. All outputs 0 except o_layer_user_reset=1. All counters 0.
- IDLE:
  - i_start -> CLEAR.
  - i_abort is ignored.
- CLEAR: o_layer_user_reset=1 for exactly 2 cycles, then -> LOAD. Clears pix_cnt, res_addr, ch_cnt and o_err.
- LOAD:
  - o_pix_ready=1, o_layer_mem_we=1.
  - On each handshake, o_layer_ce=1 for one cycle, o_layer_fmap=i_pix_data (registered, 1-cycle latency), pix_cnt increments.
  - After handshake number N_PIX: o_pix_ready drops the next cycle, state -> RUN.
  - No pixel is accepted beyond N_PIX.
- RUN:
  - o_layer_ce=1 continuously, o_layer_mem_we=0.
  - Each i_layer_en: one cycle later o_res_we=1, o_res_data=i_layer_result, o_res_addr=res_addr. res_addr then increments.
  - i_layer_ch_end: ch_cnt increments. If per-channel result count != OUT_PER_CH, set o_err.
  - i_layer_allch_end: -> DONE. The layer is not re-enabled.
  - If ch_cnt != CO when i_layer_allch_end arrives, set o_err.
- DONE:
  - o_layer_ce=0, o_done=1.
  - i_start clears o_done and -> CLEAR.
- Simultaneous events:
  - i_layer_en and i_layer_ch_end in the same cycle: the result is counted in the ending channel.
  - i_layer_en with res_addr at CO*OUT_PER_CH-1 writes normally. Any further i_layer_en is dropped and sets o_err; no address wrap.
  - i_start while o_busy sets o_err and is otherwise ignored.
- Abort: i_abort in CLEAR/LOAD/RUN -> CLEAR, then LOAD. o_err is unchanged until CLEAR clears it.
- o_ch_idx = ch_cnt saturated at CO-1.

Optional Feature:
- Macro CONV1_CTRL_PERF_EN.
- When defined, adds outputs o_cyc_load[15:0] and o_cyc_run[19:0], both saturating.
  - They count cycles spent in LOAD and in RUN.
  - Both are cleared in CLEAR and held in DONE.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package conv1_ctrl_pkg holds:
  - state encoding IDLE, CLEAR, LOAD, RUN, DONE
  - N_PIX, OUT_SIDE, OUT_PER_CH
  - the CLEAR length (2)
- One natural sub-module: conv1_res_packer. It holds the result register, the address counter, the per-channel count check and the overflow check.

Test Plan:
- Reset then i_start, stream 784 pixels with valid held high -> 784 o_layer_ce pulses in LOAD; o_pix_ready low from cycle 785; state RUN.
- Model the layer with 144 i_layer_en pulses plus ch_end per channel, for 4 channels, then allch_end -> 576 writes at addresses 0..575 with matching data; o_done=1; o_err=0; o_ch_idx=3.
- Random valid gaps of 0-5 cycles during LOAD -> exactly 784 accepted; fmap order preserved.
- Channel 1 ends after 143 results -> o_err=1; flow completes; o_done=1.
- i_abort mid-RUN (address 200) -> 2-cycle user_reset; returns to LOAD; res_addr restarts at 0 after the reload.
- i_start during LOAD -> o_err=1; no restart; pixel count unaffected.

Source files
------------

// File: rtl/conv1_ctrl_pkg.sv
// Shared definitions for the conv1 layer sequencer: FSM encoding, layer geometry and
// derived sizes, CLEAR phase length.
package conv1_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam int unsigned I_SIZE     = 28;
    localparam int unsigned K_SIZE     = 5;
    localparam int unsigned P_SIZE     = 2;
    localparam int unsigned CO         = 4;
    localparam int unsigned N_PIX      = I_SIZE * I_SIZE;
    localparam int unsigned OUT_SIDE   = (I_SIZE - K_SIZE + 1) / P_SIZE;
    localparam int unsigned OUT_PER_CH = OUT_SIDE * OUT_SIDE;
    localparam int unsigned CLR_LEN    = 2;

endpackage

// File: rtl/conv1_res_packer.sv
// Result-buffer write packer: registers pooled results, allocates flat addresses,
// tracks channels and flags per-channel count mismatches and buffer overflow.
module conv1_res_packer
    import conv1_ctrl_pkg::*;
#(
    parameter int unsigned O_BW   = 16,
    parameter int unsigned RES_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_run,
    input  logic              i_en,
    input  logic [O_BW-1:0]   i_result,
    input  logic              i_ch_end,
    input  logic              i_allch_end,
    output logic              o_res_we,
    output logic [RES_AW-1:0] o_res_addr,
    output logic [O_BW-1:0]   o_res_data,
    output logic [1:0]        o_ch_idx,
    output logic              o_err
);

    localparam int unsigned TOTAL = CO * OUT_PER_CH;
    localparam int unsigned CNT_W = $clog2(OUT_PER_CH + 1) + 1;
    localparam int unsigned CH_W  = $clog2(CO + 1);

    logic [RES_AW:0]     r_next_addr;
    logic [RES_AW-1:0]   r_addr;
    logic [O_BW-1:0]     r_data;
    logic                r_we;
    logic [CNT_W-1:0]    r_ch_res;
    logic [CH_W-1:0]     r_ch_cnt;
    logic [CNT_W-1:0]    w_ch_res_inc;
    logic [CH_W-1:0]     w_ch_cnt_inc;
    logic                w_hit;
    logic                w_full;
    logic                w_take;
    logic                w_drop;
    logic                w_ch_evt;
    logic                w_all_evt;

    assign w_hit     = i_run & i_en;
    assign w_full    = (r_next_addr == (RES_AW + 1)'(TOTAL));
    assign w_take    = w_hit & ~w_full;
    assign w_drop    = w_hit & w_full;
    assign w_ch_evt  = i_run & i_ch_end;
    assign w_all_evt = i_run & i_allch_end;

    // A result arriving with ch_end belongs to the channel that is ending
    assign w_ch_res_inc = (w_hit && (r_ch_res != '1)) ? r_ch_res + 1'b1 : r_ch_res;
    assign w_ch_cnt_inc = (w_ch_evt && (r_ch_cnt != '1)) ? r_ch_cnt + 1'b1 : r_ch_cnt;

    assign o_err = w_drop
                 | (w_ch_evt && (w_ch_res_inc != CNT_W'(OUT_PER_CH)))
                 | (w_all_evt && (w_ch_cnt_inc != CH_W'(CO)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_addr <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_ch_res    <= '0;
            r_ch_cnt    <= '0;
        end else if (i_clear) begin
            r_next_addr <= '0;
            r_we        <= 1'b0;
            r_ch_res    <= '0;
            r_ch_cnt    <= '0;
        end else begin
            r_we <= w_take;
            if (w_take) begin
                r_data      <= i_result;
                r_addr      <= r_next_addr[RES_AW-1:0];
                r_next_addr <= r_next_addr + 1'b1;
            end
            r_ch_cnt <= w_ch_cnt_inc;
            r_ch_res <= w_ch_evt ? '0 : w_ch_res_inc;
        end
    end

    assign o_res_we   = r_we;
    assign o_res_addr = r_addr;
    assign o_res_data = r_data;
    assign o_ch_idx   = (r_ch_cnt >= CH_W'(CO)) ? 2'(CO - 1) : 2'(r_ch_cnt);

endmodule

// File: rtl/conv1_layer_ctrl.sv
// Sequencer for the conv1 layer: pixel load, layer run, result packing, status.
// Optional cycle counters enabled by defining CONV1_CTRL_PERF_EN.
module conv1_layer_ctrl
    import conv1_ctrl_pkg::*;
#(
    parameter int unsigned I_BW   = 8,
    parameter int unsigned O_BW   = 16,
    parameter int unsigned PIX_AW = 10,
    parameter int unsigned RES_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_pix_valid,
    input  logic [I_BW-1:0]   i_pix_data,
    output logic              o_pix_ready,
    output logic              o_layer_ce,
    output logic              o_layer_mem_we,
    output logic [I_BW-1:0]   o_layer_fmap,
    output logic              o_layer_user_reset,
    input  logic              i_layer_en,
    input  logic [O_BW-1:0]   i_layer_result,
    input  logic              i_layer_ch_end,
    input  logic              i_layer_allch_end,
    output logic              o_res_we,
    output logic [RES_AW-1:0] o_res_addr,
    output logic [O_BW-1:0]   o_res_data,
    output logic [1:0]        o_ch_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
`ifdef CONV1_CTRL_PERF_EN
    ,
    output logic [15:0]       o_cyc_load,
    output logic [19:0]       o_cyc_run
`endif
);

    state_e            r_state;
    state_e            w_next;
    logic [1:0]        r_clr_cnt;
    logic [PIX_AW-1:0] r_pix_cnt;
    logic [I_BW-1:0]   r_fmap;
    logic              r_ce_load;
    logic              r_mem_we;
    logic              r_err;
    logic              r_done;
    logic              w_pix_ready;
    logic              w_user_reset;
    logic              w_busy;
    logic              w_hs;
    logic              w_run;
    logic              w_clear;
    logic              w_pk_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pix_ready  = 1'b0;
        w_user_reset = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            StIdle: begin
                w_user_reset = 1'b1;
                if (i_start) w_next = StClear;
            end
            StClear: begin
                w_user_reset = 1'b1;
                w_busy       = 1'b1;
                if (!i_abort && (r_clr_cnt == 2'(CLR_LEN - 1))) w_next = StLoad;
            end
            StLoad: begin
                w_pix_ready = 1'b1;
                w_busy      = 1'b1;
                if (i_abort) begin
                    w_next = StClear;
                end else if (i_pix_valid && (r_pix_cnt == PIX_AW'(N_PIX - 1))) begin
                    w_next = StRun;
                end
            end
            StRun: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_next = StClear;
                end else if (i_layer_allch_end) begin
                    w_next = StDone;
                end
            end
            StDone: begin
                if (i_start) w_next = StClear;
            end
            default: w_next = StIdle;
        endcase
    end

    assign w_hs    = w_pix_ready & i_pix_valid;
    assign w_run   = (r_state == StRun);
    assign w_clear = (r_state == StClear);

    // mem_we is delayed with fmap/ce so the final pixel's write lands in the first RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
            r_pix_cnt <= '0;
            r_fmap    <= '0;
            r_ce_load <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_clr_cnt <= (w_clear && !i_abort) ? r_clr_cnt + 1'b1 : 2'd0;
            if (w_clear) begin
                r_pix_cnt <= '0;
            end else if (w_hs) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            r_ce_load <= w_hs;
            if (w_hs) r_fmap <= i_pix_data;
            r_mem_we <= (r_state == StLoad);
            r_done   <= (w_next == StDone);
            if (w_clear) begin
                r_err <= 1'b0;
            end else if ((i_start && w_busy) || w_pk_err) begin
                r_err <= 1'b1;
            end
        end
    end

    conv1_res_packer #(
        .O_BW   (O_BW),
        .RES_AW (RES_AW)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_run       (w_run),
        .i_en        (i_layer_en),
        .i_result    (i_layer_result),
        .i_ch_end    (i_layer_ch_end),
        .i_allch_end (i_layer_allch_end),
        .o_res_we    (o_res_we),
        .o_res_addr  (o_res_addr),
        .o_res_data  (o_res_data),
        .o_ch_idx    (o_ch_idx),
        .o_err       (w_pk_err)
    );

`ifdef CONV1_CTRL_PERF_EN
    logic [15:0] r_cyc_load;
    logic [19:0] r_cyc_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_load <= '0;
            r_cyc_run  <= '0;
        end else if (w_clear) begin
            r_cyc_load <= '0;
            r_cyc_run  <= '0;
        end else begin
            if ((r_state == StLoad) && (r_cyc_load != '1)) r_cyc_load <= r_cyc_load + 1'b1;
            if (w_run && (r_cyc_run != '1)) r_cyc_run <= r_cyc_run + 1'b1;
        end
    end

    assign o_cyc_load = r_cyc_load;
    assign o_cyc_run  = r_cyc_run;
`endif

    assign o_pix_ready        = w_pix_ready;
    assign o_layer_ce         = r_ce_load | w_run;
    assign o_layer_mem_we     = r_mem_we;
    assign o_layer_fmap       = r_fmap;
    assign o_layer_user_reset = w_user_reset;
    assign o_busy             = w_busy;
    assign o_done             = r_done;
    assign o_err              = r_err;

endmodule

// File: tb/tb_conv1_layer_ctrl.sv
// Self-checking bench for conv1_layer_ctrl: scenario table plus abort and
// start-during-load sequences, against a queue-based model of pixels and results.
module tb_conv1_layer_ctrl;

    localparam int NPIX   = 784;
    localparam int PER_CH = 144;
    localparam int TOT    = 576;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_pix_valid;
    logic [7:0]  i_pix_data;
    logic        o_pix_ready, o_layer_ce, o_layer_mem_we, o_layer_user_reset;
    logic [7:0]  o_layer_fmap;
    logic        i_layer_en, i_layer_ch_end, i_layer_allch_end;
    logic [15:0] i_layer_result;
    logic        o_res_we;
    logic [9:0]  o_res_addr;
    logic [15:0] o_res_data;
    logic [1:0]  o_ch_idx;
    logic        o_busy, o_done, o_err;

    always #5 clk = ~clk;

    conv1_layer_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_abort            (i_abort),
        .i_pix_valid        (i_pix_valid),
        .i_pix_data         (i_pix_data),
        .o_pix_ready        (o_pix_ready),
        .o_layer_ce         (o_layer_ce),
        .o_layer_mem_we     (o_layer_mem_we),
        .o_layer_fmap       (o_layer_fmap),
        .o_layer_user_reset (o_layer_user_reset),
        .i_layer_en         (i_layer_en),
        .i_layer_result     (i_layer_result),
        .i_layer_ch_end     (i_layer_ch_end),
        .i_layer_allch_end  (i_layer_allch_end),
        .o_res_we           (o_res_we),
        .o_res_addr         (o_res_addr),
        .o_res_data         (o_res_data),
        .o_ch_idx           (o_ch_idx),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err)
    );

    typedef struct {
        int   cnt[4];
        int   n_ends;
        bit   coinc;
        int   gapmax;
        bit   exp_err;
        int   exp_writes;
        int   exp_ch_idx;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  pix[NPIX];
    logic [15:0] exp_res[$];
    logic [7:0]  fmap_q[$];
    logic [9:0]  waddr_q[$];
    logic [15:0] wdata_q[$];

    // Layer-side observer: BRAM writes and result-buffer writes
    always @(negedge clk) begin
        if (o_layer_ce && o_layer_mem_we) fmap_q.push_back(o_layer_fmap);
        if (o_res_we) begin
            waddr_q.push_back(o_res_addr);
            wdata_q.push_back(o_res_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int a, input int b, input int c, input int d, input int ne,
                           input bit co, input int g, input bit e, input int w, input int ci);
        vec_t v;
        v.cnt[0] = a; v.cnt[1] = b; v.cnt[2] = c; v.cnt[3] = d;
        v.n_ends = ne; v.coinc = co; v.gapmax = g;
        v.exp_err = e; v.exp_writes = w; v.exp_ch_idx = ci;
        tbl.push_back(v);
    endtask

    task automatic gen_pix();
        for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic send_range(input int first, input int n, input int gapmax);
        for (int i = first; i < first + n; i++) begin
            int g;
            int tmo;
            bit hs;
            g = $urandom_range(gapmax, 0);
            if (g > 0) begin
                i_pix_valid = 1'b0;
                repeat (g) step();
            end
            i_pix_valid = 1'b1;
            i_pix_data  = pix[i];
            hs  = 1'b0;
            tmo = 0;
            while (!hs && tmo < 200) begin
                hs = o_pix_ready;
                step();
                tmo++;
            end
            if (!hs) check("pix_accept_timeout", 0, 1);
        end
    endtask

    // Keep offering a pixel after the last one: none may be accepted
    task automatic load_tail();
        int extra;
        extra = 0;
        i_pix_valid = 1'b1;
        i_pix_data  = 8'hA5;
        check("ready_low_after_last", o_pix_ready, 0);
        repeat (4) begin
            extra += int'(o_pix_ready);
            step();
        end
        i_pix_valid = 1'b0;
        check("no_extra_accept", extra, 0);
        check("ce_in_run", o_layer_ce, 1);
        check("mem_we_off_in_run", o_layer_mem_we, 0);
    endtask

    task automatic pulse_en(input bit with_end);
        int g;
        g = $urandom_range(2, 0);
        repeat (g) step();
        i_layer_en     = 1'b1;
        i_layer_result = 16'($urandom);
        exp_res.push_back(i_layer_result);
        i_layer_ch_end = with_end;
        step();
        i_layer_en     = 1'b0;
        i_layer_ch_end = 1'b0;
    endtask

    task automatic ch_end_pulse();
        i_layer_ch_end = 1'b1;
        step();
        i_layer_ch_end = 1'b0;
    endtask

    task automatic run_layer(input vec_t v);
        exp_res.delete();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < v.cnt[c]; k++) begin
                pulse_en(v.coinc && (c < v.n_ends) && (k == v.cnt[c] - 1));
            end
            if ((c < v.n_ends) && !(v.coinc && v.cnt[c] > 0)) ch_end_pulse();
        end
        step();
        i_layer_allch_end = 1'b1;
        step();
        repeat (2) step();
        i_layer_allch_end = 1'b0;
    endtask

    task automatic check_results(input int bw, input int bf, input int exp_writes);
        int nw;
        int nf;
        int bad;
        nw = waddr_q.size() - bw;
        check("res_write_count", nw, exp_writes);
        bad = 0;
        for (int i = 0; i < nw && i < exp_writes; i++) begin
            if (waddr_q[bw + i] !== 10'(i) || wdata_q[bw + i] !== exp_res[i]) bad++;
        end
        check("res_content_bad", bad, 0);
        nf = fmap_q.size() - bf;
        check("fmap_count", nf, NPIX);
        bad = 0;
        for (int i = 0; i < nf && i < NPIX; i++) begin
            if (fmap_q[bf + i] !== pix[i]) bad++;
        end
        check("fmap_order_bad", bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int   bw;
        int   bf;
        int   ur;
        vec_t v_ok;

        add_vec(144, 144, 144, 144, 4, 1'b0, 0, 1'b0, 576, 3);
        add_vec(144, 144, 144, 144, 4, 1'b1, 5, 1'b0, 576, 3);
        add_vec(144, 143, 144, 144, 4, 1'b0, 0, 1'b1, 575, 3);
        add_vec(144, 144, 144, 145, 4, 1'b1, 2, 1'b1, 576, 3);
        add_vec(144, 144, 144,   0, 3, 1'b0, 0, 1'b1, 432, 3);
        v_ok = tbl[0];

        i_start = 0; i_abort = 0; i_pix_valid = 0; i_pix_data = 0;
        i_layer_en = 0; i_layer_result = 0; i_layer_ch_end = 0; i_layer_allch_end = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_user_reset", o_layer_user_reset, 1);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_pix_ready, 0);
        check("rst_ce", o_layer_ce, 0);
        check("rst_mem_we", o_layer_mem_we, 0);
        check("rst_res_we", o_res_we, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_ch_idx", o_ch_idx, 0);
        rst = 1'b0;
        step();

        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("idle_abort_busy", o_busy, 0);

        foreach (tbl[t]) begin
            gen_pix();
            bw = waddr_q.size();
            bf = fmap_q.size();
            start_pulse();
            check("start_clears_done", o_done, 0);
            check("start_busy", o_busy, 1);
            send_range(0, NPIX, tbl[t].gapmax);
            load_tail();
            run_layer(tbl[t]);
            check("done", o_done, 1);
            check("err", o_err, tbl[t].exp_err);
            check("ch_idx", o_ch_idx, tbl[t].exp_ch_idx);
            check("idle_busy", o_busy, 0);
            check("done_ce_off", o_layer_ce, 0);
            check_results(bw, bf, tbl[t].exp_writes);
        end

        // Abort in RUN once the write address has reached 200
        gen_pix();
        start_pulse();
        send_range(0, NPIX, 0);
        load_tail();
        exp_res.delete();
        for (int k = 0; k < PER_CH - 1; k++) pulse_en(1'b0);
        ch_end_pulse();
        for (int k = 0; k < 58; k++) pulse_en(1'b0);
        step();
        check("abort_pre_ch_idx", o_ch_idx, 1);
        check("abort_pre_err", o_err, 1);
        check("abort_pre_last_addr", waddr_q[waddr_q.size() - 1], 200);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_err_held", o_err, 1);
        ur = 0;
        while (o_layer_user_reset && ur < 10) begin
            ur++;
            step();
        end
        check("abort_clear_len", ur, 2);
        check("abort_back_to_load", o_pix_ready, 1);
        check("abort_err_cleared", o_err, 0);
        check("abort_ch_idx_reset", o_ch_idx, 0);
        gen_pix();
        bw = waddr_q.size();
        bf = fmap_q.size();
        send_range(0, NPIX, 3);
        load_tail();
        run_layer(v_ok);
        check("reload_done", o_done, 1);
        check("reload_err", o_err, 0);
        check("reload_first_addr", (waddr_q.size() > bw) ? waddr_q[bw] : 10'h3ff, 0);
        check_results(bw, bf, TOT);

        // i_start while loading: flagged, not restarted
        gen_pix();
        bw = waddr_q.size();
        bf = fmap_q.size();
        start_pulse();
        send_range(0, 300, 1);
        i_pix_valid = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("start_in_load_err", o_err, 1);
        check("start_in_load_busy", o_busy, 1);
        check("start_in_load_ready", o_pix_ready, 1);
        send_range(300, NPIX - 300, 1);
        load_tail();
        run_layer(v_ok);
        check("start_in_load_done", o_done, 1);
        check("start_in_load_err_sticky", o_err, 1);
        check_results(bw, bf, TOT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
